hp_tracker: RTL and testbench
=============================

# hp_tracker

Registered health-point tracker for the fighting-game datapath, the sequential successor to the combinational HP-bar geometry block. It holds HP for `NUM_PLAYERS` players and applies damage and heal events. It also runs per-player invulnerability timers and shared regeneration, detects end of round, and drives bar geometry and blink to the sprite/colour mapper.

## Interface

Parameters:
- `NUM_PLAYERS`, 2: player count, 2..4.
- `HP_W`, 10: HP and geometry width.
- `MAX_HP`, 200: full health; must be below 2^HP_W.
- `IFRAMES`, 30: invulnerability length in frames after an accepted hit; 0 disables.
- `REGEN_PERIOD`, 120: frames per +1 HP regeneration; 0 disables.
- `BAR_X0`, 30: x of player 0 bar.
- `BAR_STRIDE`, 340: x spacing between bars.
- `BAR_Y`, 80: bar y.
- `BAR_H`, 20: bar height.

Ports:
- `Clk` in 1: system clock; all state updates on rising edge.
- `Reset` in 1: asynchronous, active-high.
- `frame_tick` in 1: one-`Clk` pulse per video frame.
- `new_round` in 1: reload all players.
- `dmg_valid` in NUM_PLAYERS: damage request per player.
- `dmg_amt` in NUM_PLAYERS*HP_W: damage amounts; player i is at slice [i*HP_W +: HP_W].
- `heal_valid` in NUM_PLAYERS: heal request per player.
- `heal_amt` in NUM_PLAYERS*HP_W: heal amounts.
- `hp` out NUM_PLAYERS*HP_W: current HP.
- `alive` out NUM_PLAYERS: HP nonzero.
- `invuln` out NUM_PLAYERS: invulnerability timer running.
- `bar_w`, `bar_x`, `bar_y`, `bar_h` out NUM_PLAYERS*HP_W: bar geometry.
- `bar_vis` out NUM_PLAYERS: draw enable for the bar.
- `game_over` out 1: round finished.
- `draw` out 1: no survivors.
- `winner` out 2: index of the survivor.

## Operation

- FSM states: PLAY and OVER.
  - `Reset` and `new_round` both go to PLAY.
  - PLAY goes to OVER when the number of alive players is ≤1.
  - OVER stays in OVER until `new_round`.
- Reset or `new_round` sets:
  - every hp to MAX_HP, alive to all ones, and invuln counters to 0;
  - regen counter to 0, game_over/draw to 0 and winner to 0.
- `new_round` has priority over every other input in the same cycle.
- In PLAY, per player i, the following applies only while alive[i]=1:
  - **Damage** is accepted when `dmg_valid[i]` is high and invuln counter = 0.
    - hp ← max(hp − dmg_amt, 0).
    - The invuln counter loads IFRAMES.
    - Damage while invulnerable is dropped silently.
  - **Heal** is never blocked by invulnerability.
    - hp ← min(hp + heal_amt, MAX_HP).
  - **Same-cycle damage and heal:** damage applies first.
    - If the intermediate result is 0, the player dies and the heal is discarded.
    - Otherwise the heal is added to the intermediate result, clamped at MAX_HP.
  - **Regeneration:**
    - The shared counter increments on `frame_tick` and wraps at REGEN_PERIOD−1.
    - On wrap, every alive player with hp < MAX_HP gains +1.
    - Regen combines with same-cycle heal under the same clamp.
    - Regen is never applied to a player that dies that cycle.
  - The invuln counter decrements on `frame_tick` while nonzero.
- Dead players (hp = 0) ignore all events until `new_round`.
- In OVER:
  - hp is frozen.
  - dmg, heal and regen are ignored.
  - Invuln counters clear to 0.
- End-of-round outputs:
  - On entry to OVER, `game_over` = 1.
  - If exactly one player survives, `winner` = that index and `draw` = 0.
  - If no player survives, `draw` = 1 and `winner` = 0.
- Bar geometry:
  - bar_w[i] = hp[i].
  - bar_x[i] = BAR_X0 + i*BAR_STRIDE.
  - bar_y = BAR_Y and bar_h = BAR_H, constant.
- Blink: bar_vis[i] = alive[i] AND NOT (invuln[i] AND counter bit 2).
- Arithmetic:
  - Intermediates are HP_W+1 bits, so no wrap on add.
  - dmg_amt ≥ hp yields exactly 0.

## Timing

- Reset values:
  - hp = MAX_HP, alive = all ones.
  - invuln = 0, bar_vis = all ones.
  - game_over = 0, draw = 0, winner = 0.
- All outputs are registered or decoded from registers; no input-to-output combinational path.
- Latency from an event to hp, alive and invuln is 1 `Clk`.
- `game_over`, `draw` and `winner` are computed from next-state alive and update on the same edge as hp.
- Event inputs are level-sampled every `Clk` and are not frame-qualified. The driver pulses them for one cycle per event.
- Reset asserted mid-round clears asynchronously; the first edge after deassertion is normal PLAY.

## Test plan

- Reset with defaults → hp = 200,200; alive = 11; game_over = 0; bar_x = 30,370; bar_w = 200,200.
- P0 damage 50 for one cycle → next cycle hp0 = 150 and invuln[0] = 1. Damage 50 again 5 frames later → hp0 stays 150. After 30 frame_ticks, invuln[0] = 0 and a damage of 50 gives hp0 = 100.
- hp1 = 10; same cycle dmg 10 and heal 40 → hp1 = 0, alive[1] = 0; game_over = 1, winner = 0, draw = 0 on the same edge. Further events change nothing.
- hp0 = 190, heal 25 → hp0 = 200 (clamp). Separately, hp0 = 150 over 240 frame_ticks with REGEN_PERIOD = 120 → hp0 = 152.
- Both players hp = 5, both dmg 9 in the same cycle → hp = 0,0; draw = 1; game_over = 1. Then `new_round` together with dmg → hp = 200,200, game_over = 0, damage ignored.
- `Reset` pulsed while invuln[0] = 1 and hp0 = 80 → outputs return immediately to their reset values, without a clock edge.

Source files
------------

// File: rtl/hp_tracker_if.sv
// hp_tracker_if: event inputs and per-player status/geometry outputs of the HP tracker.
interface hp_tracker_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int HP_W        = 10
);
    logic                        frame_tick;
    logic                        new_round;
    logic [NUM_PLAYERS-1:0]      dmg_valid;
    logic [NUM_PLAYERS*HP_W-1:0] dmg_amt;
    logic [NUM_PLAYERS-1:0]      heal_valid;
    logic [NUM_PLAYERS*HP_W-1:0] heal_amt;

    logic [NUM_PLAYERS*HP_W-1:0] hp;
    logic [NUM_PLAYERS-1:0]      alive;
    logic [NUM_PLAYERS-1:0]      invuln;
    logic [NUM_PLAYERS*HP_W-1:0] bar_w;
    logic [NUM_PLAYERS*HP_W-1:0] bar_x;
    logic [NUM_PLAYERS*HP_W-1:0] bar_y;
    logic [NUM_PLAYERS*HP_W-1:0] bar_h;
    logic [NUM_PLAYERS-1:0]      bar_vis;
    logic                        game_over;
    logic                        draw;
    logic [1:0]                  winner;

    // Game logic side: drives events, observes state.
    modport master (
        output frame_tick, new_round, dmg_valid, dmg_amt, heal_valid, heal_amt,
        input  hp, alive, invuln, bar_w, bar_x, bar_y, bar_h, bar_vis,
        input  game_over, draw, winner
    );

    // Tracker side.
    modport slave (
        input  frame_tick, new_round, dmg_valid, dmg_amt, heal_valid, heal_amt,
        output hp, alive, invuln, bar_w, bar_x, bar_y, bar_h, bar_vis,
        output game_over, draw, winner
    );
endinterface

// File: rtl/hp_tracker.sv
// hp_tracker: registered per-player HP with damage/heal, i-frames, shared regen,
// end-of-round detection and HP bar geometry/blink.

// hp_lane: one player's HP and invulnerability counter.
module hp_lane #(
    parameter int HP_W    = 10,
    parameter int MAX_HP  = 200,
    parameter int IFRAMES = 30,
    parameter int IW      = 5
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            new_round,
    input  logic            play,
    input  logic            frame_tick,
    input  logic            regen_wrap,
    input  logic            dmg_valid,
    input  logic [HP_W-1:0] dmg_amt,
    input  logic            heal_valid,
    input  logic [HP_W-1:0] heal_amt,
    output logic [HP_W-1:0] hp,
    output logic            alive,
    output logic            alive_nxt,
    output logic            invuln,
    output logic            bar_vis
);
    localparam logic [HP_W-1:0] MAX_V = HP_W'(MAX_HP);
    localparam logic [HP_W:0]   MAX_X = (HP_W+1)'(MAX_HP);
    localparam logic [IW-1:0]   IFR_V = IW'(IFRAMES);

    logic [HP_W-1:0] hp_q, hp_d;
    logic [IW-1:0]   inv_q, inv_d;
    logic [HP_W:0]   mid, sum;
    logic            live, hit;

    assign live = (hp_q != '0);
    assign hit  = dmg_valid && (inv_q == '0);

    // Next HP: damage first, a kill discards heal/regen, survivors add heal+regen clamped.
    always_comb begin
        hp_d  = hp_q;
        inv_d = inv_q;
        mid   = '0;
        sum   = '0;
        if (new_round) begin
            hp_d  = MAX_V;
            inv_d = '0;
        end else if (!play) begin
            inv_d = '0;
        end else if (live) begin
            mid = {1'b0, hp_q};
            if (hit) begin
                mid   = (dmg_amt >= hp_q) ? '0 : {1'b0, hp_q - dmg_amt};
                inv_d = IFR_V;
            end else if (frame_tick && inv_q != '0) begin
                inv_d = inv_q - IW'(1);
            end
            if (mid == '0) begin
                hp_d = '0;
            end else begin
                sum  = mid + (heal_valid ? {1'b0, heal_amt} : '0) + (HP_W+1)'(regen_wrap);
                hp_d = (sum >= MAX_X) ? MAX_V : sum[HP_W-1:0];
            end
        end
    end

    // HP and i-frame counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hp_q  <= MAX_V;
            inv_q <= '0;
        end else begin
            hp_q  <= hp_d;
            inv_q <= inv_d;
        end
    end

    assign hp        = hp_q;
    assign alive     = live;
    assign alive_nxt = (hp_d != '0);
    assign invuln    = (inv_q != '0);
    // Bar blinks with bit 2 of the i-frame counter while invulnerable.
    assign bar_vis   = live && !(invuln && inv_q[2]);
endmodule

module hp_tracker #(
    parameter int NUM_PLAYERS  = 2,
    parameter int HP_W         = 10,
    parameter int MAX_HP       = 200,
    parameter int IFRAMES      = 30,
    parameter int REGEN_PERIOD = 120,
    parameter int BAR_X0       = 30,
    parameter int BAR_STRIDE   = 340,
    parameter int BAR_Y        = 80,
    parameter int BAR_H        = 20
) (
    input  logic         Clk,
    input  logic         Reset,
    hp_tracker_if.slave  bus
);
    // Counter keeps at least 3 bits so the blink bit always exists.
    localparam int IW = (IFRAMES < 8) ? 3 : $clog2(IFRAMES + 1);
    localparam int RW = (REGEN_PERIOD > 2) ? $clog2(REGEN_PERIOD) : 1;
    localparam logic [RW-1:0] RP_LAST = RW'((REGEN_PERIOD > 0) ? REGEN_PERIOD - 1 : 0);

    typedef enum logic {PLAY, OVER} state_t;

    state_t                      state_q, state_d;
    logic [RW-1:0]               regen_q, regen_d;
    logic                        game_over_q, game_over_d;
    logic                        draw_q, draw_d;
    logic [1:0]                  winner_q, winner_d;
    logic                        play, regen_wrap;
    logic [NUM_PLAYERS-1:0]      alive_nxt, alive_v, inv_v, vis_v;
    logic [NUM_PLAYERS*HP_W-1:0] hp_v;
    logic [2:0]                  n_alive;
    logic [1:0]                  last_idx;

    assign play       = (state_q == PLAY);
    assign regen_wrap = (REGEN_PERIOD != 0) && play && bus.frame_tick && (regen_q == RP_LAST);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
        hp_lane #(
            .HP_W    (HP_W),
            .MAX_HP  (MAX_HP),
            .IFRAMES (IFRAMES),
            .IW      (IW)
        ) u_lane (
            .Clk        (Clk),
            .Reset      (Reset),
            .new_round  (bus.new_round),
            .play       (play),
            .frame_tick (bus.frame_tick),
            .regen_wrap (regen_wrap),
            .dmg_valid  (bus.dmg_valid[i]),
            .dmg_amt    (bus.dmg_amt[i*HP_W +: HP_W]),
            .heal_valid (bus.heal_valid[i]),
            .heal_amt   (bus.heal_amt[i*HP_W +: HP_W]),
            .hp         (hp_v[i*HP_W +: HP_W]),
            .alive      (alive_v[i]),
            .alive_nxt  (alive_nxt[i]),
            .invuln     (inv_v[i]),
            .bar_vis    (vis_v[i])
        );
        assign bus.bar_x[i*HP_W +: HP_W] = HP_W'(BAR_X0 + i*BAR_STRIDE);
        assign bus.bar_y[i*HP_W +: HP_W] = HP_W'(BAR_Y);
        assign bus.bar_h[i*HP_W +: HP_W] = HP_W'(BAR_H);
    end

    assign bus.hp      = hp_v;
    assign bus.bar_w   = hp_v;
    assign bus.alive   = alive_v;
    assign bus.invuln  = inv_v;
    assign bus.bar_vis = vis_v;

    // Count survivors after this edge and remember the highest surviving index.
    always_comb begin
        n_alive  = '0;
        last_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_nxt[i]) begin
                n_alive  = n_alive + 3'd1;
                last_idx = 2'(i);
            end
        end
    end

    // Round FSM, regen counter and end-of-round result.
    always_comb begin
        state_d     = state_q;
        regen_d     = regen_q;
        game_over_d = game_over_q;
        draw_d      = draw_q;
        winner_d    = winner_q;
        if (bus.new_round) begin
            state_d     = PLAY;
            regen_d     = '0;
            game_over_d = 1'b0;
            draw_d      = 1'b0;
            winner_d    = '0;
        end else if (state_q == PLAY) begin
            if (REGEN_PERIOD != 0 && bus.frame_tick)
                regen_d = regen_wrap ? '0 : regen_q + RW'(1);
            if (n_alive <= 3'd1) begin
                state_d     = OVER;
                game_over_d = 1'b1;
                draw_d      = (n_alive == 3'd0);
                winner_d    = (n_alive == 3'd0) ? 2'd0 : last_idx;
            end
        end
    end

    // Round state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= PLAY;
            regen_q     <= '0;
            game_over_q <= 1'b0;
            draw_q      <= 1'b0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            regen_q     <= regen_d;
            game_over_q <= game_over_d;
            draw_q      <= draw_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.game_over = game_over_q;
    assign bus.draw      = draw_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_hp_tracker.sv
// tb_hp_tracker: directed test-plan scenarios plus random events, checked by a
// queue-based scoreboard against an integer reference model of the round rules.
module tb_hp_tracker;
    localparam int NP = 2, HW = 10, MAXHP = 200, IFR = 30, RP = 120;
    localparam int BX0 = 30, BS = 340, BY = 80, BH = 20;

    typedef struct packed {
        logic [NP*HW-1:0] hp, bw, bx, by, bh;
        logic [NP-1:0]    alive, inv, vis;
        logic             go, dr;
        logic [1:0]       win;
    } obs_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    hp_tracker_if #(.NUM_PLAYERS(NP), .HP_W(HW)) ifc ();

    hp_tracker #(
        .NUM_PLAYERS(NP), .HP_W(HW), .MAX_HP(MAXHP), .IFRAMES(IFR), .REGEN_PERIOD(RP),
        .BAR_X0(BX0), .BAR_STRIDE(BS), .BAR_Y(BY), .BAR_H(BH)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    int   vectors = 0, miscompares = 0;
    obs_t expq[$];

    // Reference model state
    int m_hp[NP], m_inv[NP], m_regen, m_win;
    bit m_over, m_go, m_dr;

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin m_hp[i] = MAXHP; m_inv[i] = 0; end
        m_regen = 0; m_over = 0; m_go = 0; m_dr = 0; m_win = 0;
    endfunction

    function automatic void model_step(bit fr, bit nr, logic [NP-1:0] dv, logic [NP-1:0] hv,
                                       logic [NP*HW-1:0] da, logic [NP*HW-1:0] ha);
        bit wrap;
        int n, last;
        if (nr) begin model_reset(); return; end
        if (m_over) begin
            for (int i = 0; i < NP; i++) m_inv[i] = 0;
            return;
        end
        wrap = 0;
        if (RP > 0 && fr) begin
            if (m_regen == RP - 1) begin wrap = 1; m_regen = 0; end
            else m_regen++;
        end
        for (int i = 0; i < NP; i++) begin
            int h;
            if (m_hp[i] == 0) continue;
            h = m_hp[i];
            if (dv[i] && m_inv[i] == 0) begin
                h = h - int'(da[i*HW +: HW]);
                if (h < 0) h = 0;
                m_inv[i] = IFR;
            end else if (fr && m_inv[i] > 0) begin
                m_inv[i]--;
            end
            if (h > 0) begin
                h = h + (hv[i] ? int'(ha[i*HW +: HW]) : 0) + (wrap ? 1 : 0);
                if (h > MAXHP) h = MAXHP;
            end
            m_hp[i] = h;
        end
        n = 0; last = 0;
        for (int i = 0; i < NP; i++) if (m_hp[i] > 0) begin n++; last = i; end
        if (n <= 1) begin
            m_over = 1; m_go = 1; m_dr = (n == 0); m_win = (n == 0) ? 0 : last;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t r;
        for (int i = 0; i < NP; i++) begin
            r.hp[i*HW +: HW] = HW'(m_hp[i]);
            r.bw[i*HW +: HW] = HW'(m_hp[i]);
            r.bx[i*HW +: HW] = HW'(BX0 + i*BS);
            r.by[i*HW +: HW] = HW'(BY);
            r.bh[i*HW +: HW] = HW'(BH);
            r.alive[i] = (m_hp[i] > 0);
            r.inv[i]   = (m_inv[i] > 0);
            r.vis[i]   = (m_hp[i] > 0) && !((m_inv[i] > 0) && (((m_inv[i] >> 2) & 1) == 1));
        end
        r.go = m_go; r.dr = m_dr; r.win = 2'(m_win);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r.hp = ifc.hp; r.bw = ifc.bar_w; r.bx = ifc.bar_x; r.by = ifc.bar_y; r.bh = ifc.bar_h;
        r.alive = ifc.alive; r.inv = ifc.invuln; r.vis = ifc.bar_vis;
        r.go = ifc.game_over; r.dr = ifc.draw; r.win = ifc.winner;
        return r;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h want=%h (hp got %h want %h)", nm, $time, act, exp,
                     act.hp, exp.hp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [NP*HW-1:0] pk(int a0, int a1);
        logic [NP*HW-1:0] r;
        r = '0;
        r[HW-1:0]    = HW'(a0);
        r[2*HW-1:HW] = HW'(a1);
        return r;
    endfunction

    function automatic logic [HW-1:0] ramt();
        return ($urandom_range(0, 7) == 0) ? HW'($urandom_range(0, 1023)) : HW'($urandom_range(0, 80));
    endfunction

    function automatic int hp_of(int i);
        return int'(ifc.hp[i*HW +: HW]);
    endfunction

    // Drive one cycle of events and queue the expected post-edge state.
    task automatic step(input bit fr, input bit nr, input logic [NP-1:0] dv, input logic [NP-1:0] hv,
                        input logic [NP*HW-1:0] da, input logic [NP*HW-1:0] ha);
        @(negedge Clk);
        ifc.frame_tick = fr; ifc.new_round = nr;
        ifc.dmg_valid = dv; ifc.dmg_amt = da; ifc.heal_valid = hv; ifc.heal_amt = ha;
        model_step(fr, nr, dv, hv, da, ha);
        expq.push_back(model_obs());
    endtask

    task automatic idle(input int n, input bit fr);
        for (int k = 0; k < n; k++) step(fr, 1'b0, '0, '0, '0, '0);
    endtask

    // Settle point for test-plan spot checks: just after the edge that applied the last step.
    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    // Monitor: every edge with a queued expectation is compared.
    initial begin
        forever begin
            obs_t e;
            @(posedge Clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("cycle", dut_obs(), e);
            end
        end
    end

    initial begin
        ifc.frame_tick = 0; ifc.new_round = 0;
        ifc.dmg_valid = '0; ifc.dmg_amt = '0; ifc.heal_valid = '0; ifc.heal_amt = '0;
        model_reset();
        #12;
        check("reset_state", dut_obs(), model_obs());
        chk_int("reset_bar_x1", int'(ifc.bar_x[2*HW-1:HW]), 370);
        @(negedge Clk);
        Reset = 0;

        // I-frames: hit, dropped hit, expiry, accepted hit
        step(0, 0, 2'b01, 2'b00, pk(50, 0), '0);
        settle(); chk_int("dmg_hp0", hp_of(0), 150); chk_int("dmg_inv0", int'(ifc.invuln[0]), 1);
        idle(5, 1);
        step(0, 0, 2'b01, 2'b00, pk(50, 0), '0);
        settle(); chk_int("iframe_drop_hp0", hp_of(0), 150);
        idle(25, 1);
        settle(); chk_int("iframe_expired", int'(ifc.invuln[0]), 0);
        step(0, 0, 2'b01, 2'b00, pk(50, 0), '0);
        settle(); chk_int("dmg2_hp0", hp_of(0), 100);

        // Heal clamp
        step(0, 0, 2'b00, 2'b01, '0, pk(90, 0));
        step(0, 0, 2'b00, 2'b01, '0, pk(25, 0));
        settle(); chk_int("heal_clamp", hp_of(0), 200);

        // Same-cycle lethal damage + heal ends the round
        step(0, 0, 2'b10, 2'b00, pk(0, 190), '0);
        idle(30, 1);
        step(0, 0, 2'b10, 2'b10, pk(0, 10), pk(0, 40));
        settle();
        chk_int("kill_hp1", hp_of(1), 0);
        chk_int("kill_go", int'(ifc.game_over), 1);
        chk_int("kill_winner", int'(ifc.winner), 0);
        for (int k = 0; k < 3; k++) step(1, 0, 2'b11, 2'b11, pk(20, 20), pk(50, 50));
        settle(); chk_int("over_frozen_hp0", hp_of(0), 200);

        // Regeneration over 240 frames
        step(0, 1, '0, '0, '0, '0);
        step(0, 0, 2'b01, 2'b00, pk(50, 0), '0);
        idle(240, 1);
        settle(); chk_int("regen_hp0", hp_of(0), 152);

        // Double KO, then new_round beating same-cycle damage
        step(0, 1, '0, '0, '0, '0);
        step(0, 0, 2'b11, 2'b00, pk(195, 195), '0);
        idle(30, 1);
        step(0, 0, 2'b11, 2'b00, pk(9, 9), '0);
        settle(); chk_int("draw", int'(ifc.draw), 1); chk_int("draw_go", int'(ifc.game_over), 1);
        step(0, 1, 2'b11, 2'b00, pk(50, 50), '0);
        settle(); chk_int("nr_hp1", hp_of(1), 200); chk_int("nr_go", int'(ifc.game_over), 0);

        // Asynchronous reset mid-round, no clock edge before the check
        step(0, 0, 2'b01, 2'b00, pk(120, 0), '0);
        settle();
        chk_int("pre_reset_hp0", hp_of(0), 80);
        ifc.dmg_valid = '0; ifc.heal_valid = '0; ifc.frame_tick = 0; ifc.new_round = 0;
        Reset = 1;
        #1;
        model_reset();
        check("async_reset", dut_obs(), model_obs());
        @(negedge Clk);
        Reset = 0;

        // Random events
        for (int n = 0; n < 4000; n++) begin
            logic [NP-1:0]    dv, hv;
            logic [NP*HW-1:0] da, ha;
            bit               nr;
            for (int i = 0; i < NP; i++) begin
                dv[i] = ($urandom_range(0, 19) == 0);
                hv[i] = ($urandom_range(0, 14) == 0);
                da[i*HW +: HW] = ramt();
                ha[i*HW +: HW] = ramt();
            end
            nr = m_over ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 1) == 1, nr, dv, hv, da, ha);
        end

        repeat (3) @(posedge Clk);
        #2;
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got=%0d pending want=0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
